// File: rtl/mult_pkg.sv
// Shared widths and controller state encoding for the sequential lane multiplier.
package mult_pkg;

  localparam int unsigned OPW   = 8;   // operand width
  localparam int unsigned RW    = 16;  // product width
  localparam int unsigned LANEW = 16;  // lane width on In and Out

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mult_lane.sv
// Unsigned 8x8 multiplier with a single output register (1-cycle latency).
module mult_lane
  import mult_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic [RW-1:0]  p
);

  // Full-width product registered each cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      p <= '0;
    end else begin
      p <= RW'(a) * RW'(b);
    end
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Vector multiplier: one shared registered 8x8 multiplier walked across N lanes.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANEW*N-1:0]   In,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANEW*N-1:0]   Out,
  output logic                 busy
);

  localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned VW   = LANEW * N;

  state_t          state;
  state_t          state_next;
  logic [IDXW-1:0] idx;
  logic [IDXW-1:0] idx_next;
  logic [VW-1:0]   opnd_q;
  logic [VW-1:0]   out_q;
  logic            load;
  logic            wr_en;
  logic [IDXW-1:0] wr_lane;
  logic [OPW-1:0]  mul_a;
  logic [OPW-1:0]  mul_b;
  logic [RW-1:0]   mul_p;

  // Next-state, lane counter and datapath strobes; the product of lane idx-1 lands while lane idx issues.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    load       = 1'b0;
    wr_en      = 1'b0;
    wr_lane    = '0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load       = 1'b1;
          idx_next   = '0;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (idx != '0) begin
          wr_en   = 1'b1;
          wr_lane = idx - IDXW'(1);
        end
        if (idx == IDXW'(N - 1)) begin
          idx_next   = '0;
          state_next = DRAIN;
        end else begin
          idx_next = idx + IDXW'(1);
        end
      end
      DRAIN: begin
        wr_en      = 1'b1;
        wr_lane    = IDXW'(N - 1);
        state_next = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, counter and handshake flags registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
      busy      <= (state_next != IDLE);
    end
  end

  // Select the operand pair of the lane currently being issued.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (idx == IDXW'(k)) begin
        mul_a = opnd_q[k*LANEW +: OPW];
        mul_b = opnd_q[k*LANEW + OPW +: OPW];
      end
    end
  end

  mult_lane u_mult (
    .clk (clk),
    .rst (rst),
    .a   (mul_a),
    .b   (mul_b),
    .p   (mul_p)
  );

  // Operand capture on accept; result lanes filled one per cycle and held until next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      opnd_q <= '0;
      out_q  <= '0;
    end else if (load) begin
      opnd_q <= In;
      out_q  <= '0;
    end else if (wr_en) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (wr_lane == IDXW'(k)) begin
          out_q[k*LANEW +: LANEW] <= mul_p;
        end
      end
    end
  end

  assign Out = out_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl: N=2 handshake/backpressure/reset cases and N=4 back-to-back.
module tb_mult_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [31:0] a_in, a_out;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [63:0] b_in, b_out;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mult_seq_ctrl #(.N(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .In        (a_in),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .Out       (a_out),
    .busy      (a_busy)
  );

  mult_seq_ctrl #(.N(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .In        (b_in),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .Out       (b_out),
    .busy      (b_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference products for a 4-lane vector.
  function automatic logic [63:0] ref4(input logic [63:0] v);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      r[16*k +: 16] = 16'(v[16*k +: 8]) * 16'(v[16*k + 8 +: 8]);
    end
    return r;
  endfunction

  logic [63:0] vec4 [3];

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_in = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in = '0; b_out_ready = 1'b1;
    vec4[0] = 64'h0102_0000_FFFF_80FF;
    vec4[1] = 64'h1234_5678_9ABC_DEF0;
    vec4[2] = 64'h0A0B_FF01_0707_00FF;

    step(); step();
    chk("rst_in_ready", 64'(a_in_ready), 64'd1);
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_out", 64'(a_out), 64'd0);
    rst = 1'b0;
    step();

    // Basic vector, out_valid three edges after accept
    a_in = 32'h02AB_0603; a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    chk("t1_in_ready_low", 64'(a_in_ready), 64'd0);
    chk("t1_busy", 64'(a_busy), 64'd1);
    step(); step();
    chk("t1_not_early", 64'(a_out_valid), 64'd0);
    step();
    chk("t1_out_valid", 64'(a_out_valid), 64'd1);
    chk("t1_out", 64'(a_out), 64'h0000_0000_0156_0012);
    step();
    chk("t1_idle_in_ready", 64'(a_in_ready), 64'd1);
    chk("t1_idle_out_valid", 64'(a_out_valid), 64'd0);
    chk("t1_out_retained", 64'(a_out), 64'h0000_0000_0156_0012);

    // Full-scale product plus 5 cycles of backpressure
    a_in = 32'h0508_FFFF; a_in_valid = 1'b1; a_out_ready = 1'b0;
    step();
    a_in_valid = 1'b0;
    chk("t2_out_cleared", 64'(a_out), 64'd0);
    a_in = 32'hDEAD_BEEF;
    step(); step(); step();
    for (int i = 0; i < 5; i++) begin
      chk("t2_bp_out_valid", 64'(a_out_valid), 64'd1);
      chk("t2_bp_out", 64'(a_out), 64'h0000_0000_0028_FE01);
      chk("t2_bp_in_ready", 64'(a_in_ready), 64'd0);
      chk("t2_bp_busy", 64'(a_busy), 64'd1);
      step();
    end
    a_out_ready = 1'b1;
    chk("t2_hold_out_valid", 64'(a_out_valid), 64'd1);
    step();
    chk("t2_release_in_ready", 64'(a_in_ready), 64'd1);
    chk("t2_release_busy", 64'(a_busy), 64'd0);
    chk("t2_release_out_valid", 64'(a_out_valid), 64'd0);

    // in_valid held with new data during processing is ignored
    a_in = 32'h0302_0201; a_in_valid = 1'b1;
    step();
    a_in = 32'h1010_1010;
    step(); step(); step();
    chk("t3_out_valid", 64'(a_out_valid), 64'd1);
    chk("t3_out_first_only", 64'(a_out), 64'h0000_0000_0006_0002);
    step();
    chk("t3_idle_in_ready", 64'(a_in_ready), 64'd1);
    step();
    a_in_valid = 1'b0;
    chk("t3_second_accepted", 64'(a_in_ready), 64'd0);
    step(); step(); step();
    chk("t3_second_out", 64'(a_out), 64'h0000_0000_0100_0100);
    step();

    // Reset in ISSUE with idx=1 aborts, then a fresh vector completes
    a_in = 32'h0909_0909; a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t4_rst_in_ready", 64'(a_in_ready), 64'd1);
    chk("t4_rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("t4_rst_busy", 64'(a_busy), 64'd0);
    chk("t4_rst_out", 64'(a_out), 64'd0);
    step(); step();
    chk("t4_no_partial", 64'(a_out_valid), 64'd0);
    a_in = 32'h0504_0302; a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    step(); step(); step();
    chk("t4_out_valid", 64'(a_out_valid), 64'd1);
    chk("t4_out", 64'(a_out), 64'h0000_0000_0014_0006);
    step();

    // N=4 back-to-back, one result every 7 cycles
    b_in_valid = 1'b1;
    for (int v = 0; v < 3; v++) begin
      b_in = vec4[v];
      chk("n4_in_ready_pre", 64'(b_in_ready), 64'd1);
      step();
      b_in = ~vec4[v];
      chk("n4_accepted", 64'(b_in_ready), 64'd0);
      step(); step(); step(); step();
      chk("n4_not_early", 64'(b_out_valid), 64'd0);
      step();
      chk("n4_out_valid", 64'(b_out_valid), 64'd1);
      chk("n4_out", b_out, ref4(vec4[v]));
      step();
    end
    b_in_valid = 1'b0;
    chk("n4_final_idle", 64'(b_in_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_seq_ctrl.md
MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
REQ-001 Parameter: N, default 2, number of 16-bit operand-pair lanes per vector.
REQ-002 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  operand vector on In is valid.
REQ-005 Port: in_ready  output  1  block can accept a vector this cycle.
REQ-006 Port: In  input  16*N  lane k: a = In[16k+7:16k], b = In[16k+15:16k+8], both unsigned 8-bit.
REQ-007 Port: out_valid  output  1  Out holds a complete result vector.
REQ-008 Port: out_ready  input  1  consumer accepts Out this cycle.
REQ-009 Port: Out  output  16*N  lane k: Out[16k+15:16k] = a_k * b_k, unsigned 16-bit.
REQ-010 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-011 The block SHALL time-multiplex one registered 8x8 unsigned multiplier (1-cycle latency) across all N lanes, issuing one lane per cycle.
REQ-012 FSM states SHALL be IDLE, ISSUE, DRAIN, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-013 IDLE: on in_valid&&in_ready the block SHALL capture In into an operand register, clear Out to 0, set lane index idx=0, go to ISSUE.
REQ-014 ISSUE: the multiplier inputs SHALL be lane idx of the captured operands; idx increments each cycle; after the cycle with idx=N-1 the FSM SHALL go to DRAIN.
REQ-015 The multiplier output for lane k SHALL be written into Out lane k on the edge one cycle after it is registered (writes occur during ISSUE idx>=1 and during DRAIN).
REQ-016 DRAIN: lasts exactly one cycle, writes lane N-1, then goes to DONE.
REQ-017 Latency: out_valid SHALL rise N+1 clock edges after the accepting edge; minimum vector period is N+3 cycles.
REQ-018 DONE: Out and out_valid SHALL hold stable while out_ready=0; on out_ready=1 the FSM SHALL return to IDLE on that edge.
REQ-019 in_valid while not in IDLE SHALL be ignored; In changes after acceptance SHALL NOT affect the result.
REQ-020 Products SHALL be exact full-width (0xFF*0xFF = 0xFE01); no truncation or saturation.
REQ-021 The lane counter SHALL be ceil(log2(N))-bit minimum (1 bit for N=2, no wrap before DRAIN) and SHALL support N=1 (ISSUE one cycle).
REQ-022 Out SHALL retain its last value after the DONE handshake until the next acceptance clears it.

Reset
REQ-023 With rst=1 at a rising edge: state=IDLE, idx=0, Out=0, operand register=0, multiplier output register=0.
REQ-024 Reset values: in_ready=1 (after reset edge), out_valid=0, busy=0, Out=0.
REQ-025 rst asserted mid-ISSUE/DRAIN/DONE SHALL abort the vector with no partial result ever presented; rst takes priority over all handshakes in the same cycle.

Structure
REQ-026 A shared package mult_pkg SHALL hold OPW=8, RW=16, lane width 16, and the FSM state encoding.
REQ-027 The multiplier SHALL be a sub-module mult_lane (clk, rst, a[7:0], b[7:0], p[15:0], registered output).
REQ-028 Controller FSM, lane counter, operand register and Out register SHALL reside in mult_seq_ctrl; no other sub-modules.

Verification
REQ-029 N=2, In lanes {a=03,b=06},{a=AB,b=02}, out_ready=1 -> out_valid 3 edges after accept, Out[15:0]=0x0012, Out[31:16]=0x0156.
REQ-030 N=2, lanes {FF,FF},{08,05} -> Out[15:0]=0xFE01, Out[31:16]=0x0028; then in_ready high one cycle after the DONE handshake.
REQ-031 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid=1, Out unchanged, in_ready=0, busy=1 throughout; release -> IDLE next edge.
REQ-032 in_valid held high with new In during ISSUE -> ignored; Out matches first vector only; second vector accepted only in next IDLE.
REQ-033 rst pulsed during ISSUE idx=1 -> next cycle state IDLE, Out=0, out_valid=0, in_ready=1; following vector {02,03},{04,05} yields 0x0006, 0x0014.
REQ-034 N=4 back-to-back with in_valid, out_ready always 1 -> one result per 7 cycles, each lane product correct against a reference model.
